// File: rtl/hv_gen_arbiter.sv
// Round-robin share of one sparse HV segment generator; grant 1 cycle after req, push-to-out_valid 1 cycle.
// Generator stream cannot stall: a per-HV buffer absorbs it while out_ready throttles the consumer side.
module hv_gen_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int LENGTH_SEGMENT = 32,
    parameter int NB_OF_SEGMENTS = 32
) (
    input  logic                              clk,
    input  logic                              arst_n_in,
    input  logic [NUM_REQ-1:0]                req,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              gen_start,
    input  logic                              gen_seg_valid,
    input  logic [LENGTH_SEGMENT-1:0]         gen_seg_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LENGTH_SEGMENT-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]        out_id,
    output logic [$clog2(NB_OF_SEGMENTS)-1:0] out_seg_idx,
    output logic                              out_last,
    output logic                              busy,
    output logic                              err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int IW  = $clog2(NB_OF_SEGMENTS);
    localparam int CW  = IW + 1;

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t                    state, state_nxt;
    logic [IDW-1:0]            rr_ptr;
    logic [IDW-1:0]            pick;
    logic [IDW-1:0]            cand;
    logic                      pick_vld;
    logic [CW-1:0]             rx_cnt;
    logic [LENGTH_SEGMENT-1:0] mem [NB_OF_SEGMENTS];
    logic                      push;
    logic                      hs;
    logic                      done;

    // Every HV writes exactly NB_OF_SEGMENTS entries from slot 0, so the
    // receive count is the write address and the segment index the read address.
    assign push      = (state == RUN) && gen_seg_valid && (rx_cnt < CW'(NB_OF_SEGMENTS));
    assign out_valid = (state == RUN) && (rx_cnt != {1'b0, out_seg_idx});
    assign out_last  = out_valid && (out_seg_idx == IW'(NB_OF_SEGMENTS - 1));
    assign out_data  = out_valid ? mem[out_seg_idx] : '0;
    assign hs        = out_valid && out_ready;
    assign done      = hs && out_last;
    assign gen_start = (state == START);
    assign busy      = (state != IDLE);

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            gnt         <= '0;
            out_id      <= '0;
            rr_ptr      <= '0;
            rx_cnt      <= '0;
            out_seg_idx <= '0;
            err         <= 1'b0;
        end else begin
            if (state == IDLE && pick_vld) begin
                gnt    <= NUM_REQ'(1) << pick;
                out_id <= pick;
            end
            if (state == START) begin
                rx_cnt      <= '0;
                out_seg_idx <= '0;
            end
            if (push) rx_cnt <= rx_cnt + 1'b1;
            if (hs)   out_seg_idx <= out_seg_idx + 1'b1;
            if (done) begin
                gnt    <= '0;
                rr_ptr <= (out_id == IDW'(NUM_REQ - 1)) ? '0 : out_id + 1'b1;
            end
            if (gen_seg_valid && state != RUN) err <= 1'b1;
            if (gen_seg_valid && state == RUN && rx_cnt == CW'(NB_OF_SEGMENTS)) err <= 1'b1;
            if (push && $countones(gen_seg_data) != 1) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[rx_cnt[IW-1:0]] <= gen_seg_data;
    end
endmodule
